prog_fetch_unit: RTL

Parametrised instruction-fetch sequencer between the program ROM and proc. It replaces the bare pc_addr counter with the following features:
- fetch program counter with wrap/halt control;
- latency-tolerant ROM interface;
- small prefetch queue;
- branch load (ld_pc) with flush of stale words.

proc pops words with pc_inc. The ROM must be clocked by PClock.

---
 rtl/pfu_pkg.sv | 15 +
 rtl/pfu_queue.sv | 60 ++++++
 rtl/prog_fetch_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pfu_pkg.sv
// Shared types and helpers for the program fetch unit and its prefetch queue.
package pfu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pfu_state_t;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int unsigned pfu_occ_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pfu_queue.sv
// Synchronous FIFO with flush; head word reads as zero while empty.
module pfu_queue
  import pfu_pkg::*;
#(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          PClock,
  input  logic                          Resetn,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          pop,
  input  logic                          flush,
  output logic [WIDTH-1:0]              rdata,
  output logic [pfu_occ_w(DEPTH)-1:0]   count,
  output logic                          empty,
  output logic                          full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = pfu_occ_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge PClock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: unread entries are masked by empty.
  always_ff @(posedge PClock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/prog_fetch_unit.sv
// Instruction-fetch sequencer: fetch PC, ROM in-flight tag pipe, prefetch queue, branch flush.
// Optional breakpoint halt is built when PFU_BREAKPOINT_EN is defined.
module prog_fetch_unit
  import pfu_pkg::*;
#(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned Q_DEPTH = 2,
  parameter int unsigned WRAP    = 1
) (
  input  logic                            PClock,
  input  logic                            Resetn,
  input  logic                            Run,
  input  logic                            pc_inc,
  input  logic                            ld_pc,
  input  logic [ADDR_W-1:0]               ld_addr,
  input  logic [DATA_W-1:0]               rom_data,
`ifdef PFU_BREAKPOINT_EN
  input  logic                            bkpt_en,
  input  logic [ADDR_W-1:0]               bkpt_addr,
  output logic                            bkpt_hit,
`endif
  output logic [ADDR_W-1:0]               rom_addr,
  output logic [DATA_W-1:0]               instr,
  output logic [ADDR_W-1:0]               instr_addr,
  output logic                            instr_valid,
  output logic                            halted,
  output logic [pfu_occ_w(Q_DEPTH)-1:0]   occupancy
);

  localparam int unsigned OCC_W = pfu_occ_w(Q_DEPTH);
  localparam int unsigned CRD_W = OCC_W + 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } pfu_entry_t;

  localparam int unsigned ENTRY_W = $bits(pfu_entry_t);

  pfu_state_t                     state;
  pfu_state_t                     state_nxt;
  logic [ADDR_W-1:0]              fetch_pc;
  logic [ROM_LAT-1:0]             pipe_v;
  logic [ROM_LAT-1:0][ADDR_W-1:0] pipe_a;
  logic [ROM_LAT-1:0]             pipe_v_nxt;
  logic [ROM_LAT-1:0][ADDR_W-1:0] pipe_a_nxt;
  logic                           issue;
  logic                           pop_fire;
  logic                           ret_push;
  logic                           bkpt_stop;
  logic                           credit_ok;
  logic [CRD_W-1:0]               credit_used;
  pfu_entry_t                     q_wdata;
  pfu_entry_t                     q_rdata;
  logic                           q_empty;
  logic                           q_full;

`ifdef PFU_BREAKPOINT_EN
  assign bkpt_stop = bkpt_en && (fetch_pc == bkpt_addr);
`else
  assign bkpt_stop = 1'b0;
`endif

  // A word popped on this edge frees its slot, which is what allows 1 word/cycle.
  assign pop_fire    = pc_inc && !q_empty && !ld_pc;
  assign ret_push    = pipe_v[ROM_LAT-1] && !ld_pc;
  assign credit_used = CRD_W'(occupancy) + CRD_W'($countones(pipe_v)) - CRD_W'(pop_fire);
  assign credit_ok   = (credit_used < CRD_W'(Q_DEPTH)) && !(q_full && !pop_fire);

  assign rom_addr    = fetch_pc;
  assign instr       = q_rdata.data;
  assign instr_addr  = q_rdata.addr;
  assign instr_valid = !q_empty;

  always_comb begin
    q_wdata      = '0;
    q_wdata.data = rom_data;
    q_wdata.addr = pipe_a[ROM_LAT-1];
  end

  always_ff @(posedge PClock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Run) state_nxt = RUN;
      RUN: begin
        if (!Run)                                          state_nxt = IDLE;
        else if (!ld_pc && bkpt_stop)                      state_nxt = HALT;
        else if (issue && (WRAP == 0) && (fetch_pc == '1)) state_nxt = HALT;
      end
      HALT: if (ld_pc) state_nxt = Run ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue  = 1'b0;
    halted = 1'b0;
    case (state)
      RUN:     issue  = Run && !ld_pc && !bkpt_stop && credit_ok;
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  // Tag pipe tracks which ROM reads are still worth keeping; ld_pc kills them all.
  generate
    if (ROM_LAT > 1) begin : g_deep
      assign pipe_v_nxt = ld_pc ? '0 : {pipe_v[ROM_LAT-2:0], issue};
      assign pipe_a_nxt = {pipe_a[ROM_LAT-2:0], fetch_pc};
    end else begin : g_single
      assign pipe_v_nxt = issue;
      assign pipe_a_nxt = fetch_pc;
    end
  endgenerate

  always_ff @(posedge PClock or negedge Resetn) begin
    if (!Resetn) begin
      fetch_pc <= '0;
      pipe_v   <= '0;
      pipe_a   <= '0;
    end else begin
      if (ld_pc)      fetch_pc <= ld_addr;
      else if (issue) fetch_pc <= fetch_pc + ADDR_W'(1);
      pipe_v <= pipe_v_nxt;
      pipe_a <= pipe_a_nxt;
    end
  end

`ifdef PFU_BREAKPOINT_EN
  always_ff @(posedge PClock or negedge Resetn) begin
    if (!Resetn)                                 bkpt_hit <= 1'b0;
    else if (ld_pc)                              bkpt_hit <= 1'b0;
    else if ((state == RUN) && Run && bkpt_stop) bkpt_hit <= 1'b1;
  end
`endif

  pfu_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .PClock (PClock),
    .Resetn (Resetn),
    .push   (ret_push),
    .wdata  (q_wdata),
    .pop    (pop_fire),
    .flush  (ld_pc),
    .rdata  (q_rdata),
    .count  (occupancy),
    .empty  (q_empty),
    .full   (q_full)
  );

endmodule
